ysyx_store_queue: RTL and testbench

//  In-order committed-store buffer between ROU store commit and LSU bus write channel.

---
 rtl/ysyx_pkg.sv | 21 ++
 rtl/ysyx_sq_fwd.sv | 40 ++++
 rtl/ysyx_store_queue.sv | 90 +++++++++
 tb/tb_ysyx_store_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_pkg.sv
// ysyx_pkg: shared store-queue types and helpers.
// Contents: XLEN default (YSYX_XLEN, 32 when not predefined), store-op encodings of
// alu[1:0], the queue entry struct {addr, data, mask}, and the byte-mask generator.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
package ysyx_pkg;
    localparam int SQ_XLEN = `YSYX_XLEN;
    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;
    typedef struct packed {
        logic [SQ_XLEN-1:0] addr;
        logic [SQ_XLEN-1:0] data;
        logic [3:0]         mask;
    } sq_entry_t;
    // Unshifted byte mask; lane placement by addr[1:0] happens at the output.
    function automatic logic [3:0] sq_mask(input logic [1:0] op);
        return op == ST_SB ? 4'b0001 : op == ST_SH ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/ysyx_sq_fwd.sv
// ysyx_sq_fwd: youngest-match store-to-load forwarding search over the queue.
// Ports: entries/head/count describe the live FIFO contents; ld_word is the load word
// address (ld_addr[XLEN-1:2]); ld_fwd_hit/ld_fwd_data report a full-word forward,
// ld_conflict reports an overlapping store that only partially covers the word.
module ysyx_sq_fwd
    import ysyx_pkg::*;
#(
    parameter int SQ_SIZE = 4,
    localparam int PW = $clog2(SQ_SIZE)
) (
    input  sq_entry_t          entries [SQ_SIZE],
    input  logic [PW-1:0]      head,
    input  logic [PW:0]        count,
    input  logic [SQ_XLEN-3:0] ld_word,
    output logic               ld_fwd_hit,
    output logic [SQ_XLEN-1:0] ld_fwd_data,
    output logic               ld_conflict
);
    logic          match;
    logic [PW-1:0] idx;
    logic [3:0]    lane;
    sq_entry_t     sel;
    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        match = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            idx = head + PW'(i);
            if ((PW + 1)'(i) < count && entries[idx].addr[SQ_XLEN-1:2] == ld_word) begin
                match = 1'b1;
                sel   = entries[idx];
            end
        end
        lane        = sel.mask << sel.addr[1:0];
        ld_fwd_hit  = match && lane == 4'hF;
        ld_conflict = match && lane != 4'hF;
        ld_fwd_data = ld_fwd_hit ? sel.data << {sel.addr[1:0], 3'b000} : '0;
    end
endmodule

// File: rtl/ysyx_store_queue.sv
// ysyx_store_queue: in-order committed-store buffer draining to the LSU write channel.
// Ports: clock/reset_n (async active-low); cm_* commit-side store input, sq_ready
// backpressure; sq_empty for fence drain; awaddr/awvalid/wdata/wstrb/wvalid/wready bus
// write head; ld_addr/ld_fwd_hit/ld_fwd_data/ld_conflict load lookup.
// Build option: YSYX_SQ_FWD_EN enables store-to-load forwarding; otherwise any queued
// store makes loads wait (ld_conflict = ~sq_empty).
module ysyx_store_queue
    import ysyx_pkg::*;
#(
    parameter int SQ_SIZE = 4,
    parameter int XLEN = SQ_XLEN,
    localparam int PW = $clog2(SQ_SIZE),
    localparam int CW = PW + 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            cm_valid,
    input  logic            cm_store,
    input  logic [4:0]      cm_alu,
    input  logic [XLEN-1:0] cm_waddr,
    input  logic [XLEN-1:0] cm_wdata,
    output logic            sq_ready,
    output logic            sq_empty,
    output logic [XLEN-1:0] awaddr,
    output logic            awvalid,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic            wvalid,
    input  logic            wready,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_fwd_hit,
    output logic [XLEN-1:0] ld_fwd_data,
    output logic            ld_conflict
);
    sq_entry_t     entries [SQ_SIZE];
    sq_entry_t     hd;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          misal, push, pop;
    logic          unused_in;
    assign misal    = (cm_alu[1:0] == ST_SH && cm_waddr[0]) ||
                      (cm_alu[1:0] == ST_SW && cm_waddr[1:0] != 2'b00);
    assign sq_ready = count != CW'(SQ_SIZE);
    assign sq_empty = count == '0;
    assign push     = cm_valid && cm_store && sq_ready && !misal;
    assign awvalid  = !sq_empty;
    assign wvalid   = awvalid;
    assign pop      = awvalid && wready;
    assign hd       = entries[head];
    // Outputs are forced to zero when idle so stale entries never reach the bus.
    assign awaddr   = awvalid ? {hd.addr[XLEN-1:2], 2'b00} : '0;
    assign wdata    = awvalid ? hd.data << {hd.addr[1:0], 3'b000} : '0;
    assign wstrb    = awvalid ? {4'b0000, hd.mask << hd.addr[1:0]} : '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < SQ_SIZE; i++) entries[i] <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{addr: cm_waddr, data: cm_wdata, mask: sq_mask(cm_alu[1:0])};
                tail          <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifdef YSYX_SQ_FWD_EN
    assign unused_in = ^{cm_alu[4:2], ld_addr[1:0]};
    ysyx_sq_fwd #(.SQ_SIZE(SQ_SIZE)) u_fwd (
        .entries     (entries),
        .head        (head),
        .count       (count),
        .ld_word     (ld_addr[XLEN-1:2]),
        .ld_fwd_hit  (ld_fwd_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_conflict (ld_conflict)
    );
`else
    assign unused_in   = ^{cm_alu[4:2], ld_addr};
    assign ld_fwd_hit  = 1'b0;
    assign ld_fwd_data = '0;
    assign ld_conflict = !sq_empty;
`endif
    a_no_push_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(cm_valid && cm_store && !sq_ready));
    a_aligned: assert property (@(posedge clock) disable iff (!reset_n)
        !(cm_valid && cm_store && misal));
endmodule

// File: tb/tb_ysyx_store_queue.sv
// tb_ysyx_store_queue: randomized scoreboard bench for ysyx_store_queue.
module tb_ysyx_store_queue;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
    } st_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cm_valid = 1'b0, cm_store = 1'b0, wready = 1'b0;
    logic [4:0]  cm_alu = '0;
    logic [31:0] cm_waddr = '0, cm_wdata = '0, ld_addr = '0;
    logic        sq_ready, sq_empty, awvalid, wvalid, ld_fwd_hit, ld_conflict;
    logic [31:0] awaddr, wdata, ld_fwd_data;
    logic [7:0]  wstrb;

    st_t exp_q[$];
    int  checks = 0, errors = 0;
    bit  mon_en = 1'b0;

    ysyx_store_queue dut (
        .clock(clock), .reset_n(reset_n), .cm_valid(cm_valid), .cm_store(cm_store),
        .cm_alu(cm_alu), .cm_waddr(cm_waddr), .cm_wdata(cm_wdata), .sq_ready(sq_ready),
        .sq_empty(sq_empty), .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .ld_addr(ld_addr),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_conflict(ld_conflict)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_strb(input st_t s);
        int m = s.op == 2'd0 ? 1 : s.op == 2'd1 ? 3 : 15;
        return 8'((m << s.addr[1:0]) & 15);
    endfunction

    function automatic logic [31:0] exp_wdata(input st_t s);
        return s.data << (8 * s.addr[1:0]);
    endfunction

    function automatic void fwd_model(input logic [31:0] la, output logic hit,
                                      output logic conf, output logic [31:0] d);
        hit = 1'b0; conf = 1'b0; d = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].addr[31:2] == la[31:2]) begin
                hit  = exp_strb(exp_q[i]) == 8'h0F;
                conf = !hit;
                d    = hit ? exp_wdata(exp_q[i]) : 32'h0;
                return;
            end
    endfunction

    // Monitor: compare the bus head and status against the scoreboard every cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            logic        h, c;
            logic [31:0] d;
            st_t         s;
            chk("awvalid", 32'(awvalid), 32'(exp_q.size() != 0));
            chk("wvalid", 32'(wvalid), 32'(exp_q.size() != 0));
            chk("sq_ready", 32'(sq_ready), 32'(exp_q.size() != 4));
            chk("sq_empty", 32'(sq_empty), 32'(exp_q.size() == 0));
`ifdef YSYX_SQ_FWD_EN
            fwd_model(ld_addr, h, c, d);
            chk("ld_fwd_hit", 32'(ld_fwd_hit), 32'(h));
            chk("ld_conflict", 32'(ld_conflict), 32'(c));
            if (h) chk("ld_fwd_data", ld_fwd_data, d);
`else
            h = 1'b0; c = exp_q.size() != 0; d = '0;
            chk("ld_fwd_hit", 32'(ld_fwd_hit), 32'(h));
            chk("ld_conflict", 32'(ld_conflict), 32'(c));
`endif
            if (exp_q.size() != 0) begin
                s = exp_q[0];
                chk("awaddr", awaddr, {s.addr[31:2], 2'b00});
                chk("wdata", wdata, exp_wdata(s));
                chk("wstrb", 32'(wstrb), 32'(exp_strb(s)));
                if (wready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; an accepted store enters the scoreboard at the edge.
    task automatic cyc(input logic v, input logic st, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [31:0] la);
        bit acc;
        cm_valid = v; cm_store = st; cm_alu = {3'b000, op};
        cm_waddr = a; cm_wdata = d; wready = wr; ld_addr = la;
        acc = v && st && sq_ready;
        @(posedge clock);
        if (acc) exp_q.push_back('{addr: a, data: d, op: op});
        #1;
    endtask

    task automatic idle(input logic wr, input logic [31:0] la);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, wr, la);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1'b1, 32'h0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic rnd_store(input logic wr);
        logic [1:0]  op = 2'($urandom_range(0, 2));
        logic [31:0] a  = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
        logic [31:0] d  = $urandom;
        logic [31:0] la = 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if (op == 2'd0) begin a = a | $urandom_range(0, 3); d = d & 32'hFF; end
        if (op == 2'd1) begin a = a | (2 * $urandom_range(0, 1)); d = d & 32'hFFFF; end
        if (sq_ready && $urandom_range(0, 1) == 1) cyc(1'b1, 1'b1, op, a, d, wr, la);
        else cyc(1'($urandom_range(0, 1)), 1'b0, op, a, d, wr, la);
    endtask

    initial begin
        #12;
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_sq_ready", 32'(sq_ready), 1);
        chk("rst_sq_empty", 32'(sq_empty), 1);
        chk("rst_hit", 32'(ld_fwd_hit), 0);
        chk("rst_conflict", 32'(ld_conflict), 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", 32'(wstrb), 0);
        #10 reset_n = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;
        // SW aligned, then SB in the top byte lane
        cyc(1'b1, 1'b1, 2'd2, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
        cyc(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 1'b1, 32'h0);
        drain();
        // fill to full, then a single-cycle wready pulse
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 2'd2, 32'h8000_0100 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b0, 32'h0);
        drain();
        // simultaneous push and pop at count 2 wraps the pointers
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'b1, 2'd1, 32'h8000_0202 + 32'(i * 4), 32'h00A0 + 32'(i), 1'b0, 32'h0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 2'd2, 32'h8000_0300 + 32'(i * 4), 32'h5000 + 32'(i), 1'b1, 32'h0);
        drain();
        // forwarding: youngest full-word store wins; partial store conflicts
        cyc(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'h1111_1111, 1'b0, 32'h8000_0010);
        cyc(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'h2222_2222, 1'b0, 32'h8000_0010);
        idle(1'b0, 32'h8000_0010);
        cyc(1'b1, 1'b1, 2'd0, 32'h8000_0020, 32'h0000_0055, 1'b0, 32'h8000_0020);
        idle(1'b0, 32'h8000_0020);
        idle(1'b0, 32'h8000_0030);
        drain();
        // randomized traffic
        for (int i = 0; i < 400; i++) rnd_store(1'($urandom_range(0, 1)));
        drain();
        // asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 2'd2, 32'h8000_0400 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_awvalid", 32'(awvalid), 0);
        chk("arst_sq_empty", 32'(sq_empty), 1);
        chk("arst_wstrb", 32'(wstrb), 0);
        exp_q.delete();
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) idle(1'b1, 32'h8000_0400);
        for (int i = 0; i < 100; i++) rnd_store(1'($urandom_range(0, 1)));
        drain();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
